// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Valid/ready input handshake; the BCD result is registered and held between conversions.
module bin2bcd_seq #(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       i_bin,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_valid,
  output logic                  o_ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  function automatic logic [63:0] calc_max(input int d);
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < d; i++) m = m * 64'd10;
    return m - 64'd1;
  endfunction

  localparam logic [63:0]      MAX_VAL  = calc_max(DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                    state_reg, state_next;
  logic [IN_W-1:0]           bin_reg;
  logic [BCD_W-1:0]          scratch_reg;
  logic [BCD_W-1:0]          adj;
  logic [BCD_W+IN_W-1:0]     shifted;
  logic [CNT_W-1:0]          cnt_reg;
  logic                      ovf_pending_reg;
  logic                      accept;

  assign o_ready = (state_reg == IDLE);
  assign accept  = o_ready && i_valid;

  // Add 3 to every digit >= 5 before the shift so each digit carries correctly at 10.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                              scratch_reg[4*gi +: 4] + 4'd3 : scratch_reg[4*gi +: 4];
    end
  endgenerate

  assign shifted = {adj, bin_reg} << 1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (cnt_reg == LAST_CNT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg         <= '0;
      scratch_reg     <= '0;
      cnt_reg         <= '0;
      ovf_pending_reg <= 1'b0;
      o_bcd           <= '0;
      o_ovf           <= 1'b0;
      o_valid         <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            bin_reg         <= i_bin;
            scratch_reg     <= '0;
            cnt_reg         <= '0;
            ovf_pending_reg <= (64'(i_bin) > MAX_VAL);
          end
        end
        SHIFT: begin
          scratch_reg <= shifted[BCD_W+IN_W-1:IN_W];
          bin_reg     <= shifted[IN_W-1:0];
          cnt_reg     <= cnt_reg + CNT_W'(1);
        end
        DONE: begin
          // Out-of-range operands saturate to all nines; dropped top carries are irrelevant then.
          o_bcd   <= ovf_pending_reg ? {DIGITS{4'h9}} : scratch_reg;
          o_ovf   <= ovf_pending_reg;
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases, handshake timing, reset abort
// and random values compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  localparam int IN_W   = 14;
  localparam int DIGITS = 4;
  localparam int MAXV   = 9999;

  logic        clk = 1'b0;
  logic        rst;
  logic [IN_W-1:0] i_bin;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_bcd;
  logic        o_valid;
  logic        o_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .i_bin(i_bin), .i_valid(i_valid),
    .o_ready(o_ready), .o_bcd(o_bcd), .o_valid(o_valid), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_bcd(input int unsigned v);
    int unsigned x;
    logic [15:0] r;
    if (v > MAXV) return 16'h9999;
    x = v;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present v and hold i_valid until accepted; returns #1 after the accepting edge.
  task automatic start(input int unsigned v);
    int n;
    n = 0;
    @(negedge clk);
    i_bin = IN_W'(v);
    i_valid = 1'b1;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  // Wait for the result of the conversion just accepted and check value and timing.
  task automatic finish_conv(input int unsigned v, input string tag);
    int lat, rdy_low;
    bit got;
    lat = 0; rdy_low = 0; got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (!o_ready) rdy_low++;
      if (o_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    check({tag, "_got_valid"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd16);
    check({tag, "_ready_low"}, 32'(rdy_low), 32'd15);
    check({tag, "_bcd"}, 32'(o_bcd), 32'(ref_bcd(v)));
    check({tag, "_ovf"}, 32'(o_ovf), 32'(v > MAXV));
    $display("conv %0d -> bcd %h ovf %0b", v, o_bcd, o_ovf);
  endtask

  int unsigned dir_vals[8] = '{0, 9, 10, 99, 4095, 9999, 1000, 9998};
  logic [15:0] hold_bcd;
  int vcount;
  int accepts, results, last_acc;
  int unsigned exp_q[$];
  int unsigned rv;
  bit acc;

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_bin = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_bcd", 32'(o_bcd), 32'h0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);

    // Directed values, including the top of the range
    foreach (dir_vals[i]) begin
      start(dir_vals[i]);
      finish_conv(dir_vals[i], "dir");
    end

    // Result held with i_valid low
    hold_bcd = o_bcd;
    vcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_valid) vcount++;
    end
    check("hold_bcd", 32'(o_bcd), 32'(hold_bcd));
    check("hold_no_valid", 32'(vcount), 32'd0);

    // Saturation, then recovery
    start(10000);  finish_conv(10000, "sat_lo");
    start(16383);  finish_conv(16383, "sat_hi");
    start(42);     finish_conv(42, "after_sat");

    // Busy: i_valid pulsed and i_bin changed during SHIFT must be ignored
    start(1234);
    @(negedge clk);
    @(negedge clk);
    i_bin = IN_W'(55);
    i_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (o_valid) got = 1'b1;
      end
      check("busy_got_valid", 32'(got), 32'd1);
      check("busy_bcd", 32'(o_bcd), 32'(ref_bcd(1234)));
      $display("busy conv 1234 -> bcd %h", o_bcd);
    end
    repeat (3) @(negedge clk);
    check("busy_not_queued", 32'(o_ready), 32'd1);

    // Streaming: i_valid held high, operand incremented on each accept
    accepts = 0; results = 0; last_acc = -1;
    @(negedge clk);
    i_bin = IN_W'(500);
    i_valid = 1'b1;
    for (int k = 0; k < 200 && results < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (o_valid) begin
        check("stream_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          rv = exp_q.pop_front();
          check("stream_bcd", 32'(o_bcd), 32'(ref_bcd(rv)));
          $display("stream result %0d -> bcd %h", rv, o_bcd);
        end
        results++;
      end
      acc = o_ready && i_valid;
      if (acc) exp_q.push_back(32'(i_bin));
      @(posedge clk);
      #1;
      if (acc) begin
        if (last_acc >= 0) check("stream_spacing", 32'(cyc - last_acc), 32'd16);
        last_acc = cyc;
        accepts++;
        i_bin = i_bin + 1'b1;
        if (accepts == 6) i_valid = 1'b0;
      end
    end
    check("stream_accepts", 32'(accepts), 32'd6);
    check("stream_results", 32'(results), 32'd6);

    // Restore a known previous result, then abort a conversion with reset
    start(42); finish_conv(42, "pre_rst");
    start(1234);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_bcd", 32'(o_bcd), 32'h0);
    check("abort_ovf", 32'(o_ovf), 32'd0);
    check("abort_ready", 32'(o_ready), 32'd1);
    vcount = 0;
    repeat (20) begin
      if (o_valid) vcount++;
      @(negedge clk);
    end
    check("abort_no_valid", 32'(vcount), 32'd0);
    $display("reset abort: bcd %h ready %0b", o_bcd, o_ready);
    start(77); finish_conv(77, "after_rst");

    // Random values across the full input range
    for (int i = 0; i < 600; i++) begin
      rv = (i % 4 == 0) ? $urandom_range(9990, 16383) : $urandom_range(0, 9999);
      start(rv);
      finish_conv(rv, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
